// File: rtl/fifo_mem_mode.sv
// ============================================================================
// Module   : fifo_mem_mode
// Brief    : Synchronous FIFO with registered-read or first-word-fall-through
//            output, occupancy flags and sticky overflow/underflow errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem_mode #(
    parameter int DATA_WIDTH         = 16,
    parameter int OSTD_NUM           = 8,
    parameter int THRESHOLD_VALUE    = OSTD_NUM / 2,
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int FWFT               = 0
) (
    input  logic                        clk_in,
    input  logic                        areset_b,
    input  logic                        flush,
    input  logic                        err_clr,
    input  logic                        trans_write,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        trans_read,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        data_valid,
    output logic [$clog2(OSTD_NUM):0]   count,
    output logic                        full_ind,
    output logic                        empty_ind,
    output logic                        threshold_ind,
    output logic                        almost_empty_ind,
    output logic                        overflow_ind,
    output logic                        underflow_ind
);

    localparam int c_ptr_w = $clog2(OSTD_NUM);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_full_lvl   = c_cnt_w'(OSTD_NUM);
    localparam logic [c_cnt_w-1:0] c_thresh_lvl = c_cnt_w'(THRESHOLD_VALUE);
    localparam logic [c_cnt_w-1:0] c_aempty_lvl = c_cnt_w'(ALMOST_EMPTY_VALUE);

    logic [DATA_WIDTH-1:0] r_mem [OSTD_NUM];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_wr_en;
    logic w_rd_en;
    logic w_wr_err;
    logic w_rd_err;
    logic [DATA_WIDTH-1:0] w_head;

    // Flags come straight from the registered count, so they track reset
    // immediately through the asynchronous clear of r_count.
    assign full_ind         = (r_count == c_full_lvl);
    assign empty_ind        = (r_count == '0);
    assign threshold_ind    = (r_count >= c_thresh_lvl);
    assign almost_empty_ind = (r_count <= c_aempty_lvl);
    assign count            = r_count;
    assign overflow_ind     = r_overflow;
    assign underflow_ind    = r_underflow;

    assign w_wr_en  = trans_write && !full_ind  && !flush;
    assign w_rd_en  = trans_read  && !empty_ind && !flush;
    assign w_wr_err = trans_write &&  full_ind  && !flush;
    assign w_rd_err = trans_read  &&  empty_ind && !flush;
    assign w_head   = r_mem[r_rd_ptr];

    // Storage is deliberately not reset; the cleared count keeps it unreadable.
    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky errors: a new error on the same edge as err_clr stays set.
    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_err) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_err) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out   = empty_ind ? '0 : w_head;
            assign data_valid = !empty_ind;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_data_out;
            logic                  r_data_valid;

            always_ff @(posedge clk_in or negedge areset_b) begin
                if (!areset_b) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else if (flush) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_en;
                    if (w_rd_en) begin
                        r_data_out <= w_head;
                    end
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_mem_mode.sv
// ============================================================================
// Module   : tb_fifo_mem_mode
// Brief    : Directed self-checking bench for fifo_mem_mode in both read modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_mem_mode;

    logic        clk_in = 1'b0;
    logic        areset_b;
    logic        flush, err_clr, trans_write, trans_read;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  count;
    logic        full_ind, empty_ind, threshold_ind, almost_empty_ind;
    logic        overflow_ind, underflow_ind;

    logic        f_flush, f_err_clr, f_wr, f_rd;
    logic [15:0] f_din;
    logic [15:0] f_out;
    logic        f_valid;
    logic [3:0]  f_count;
    logic        f_full, f_empty, f_thresh, f_aempty, f_ovf, f_unf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    fifo_mem_mode #(
        .DATA_WIDTH(16), .OSTD_NUM(8), .THRESHOLD_VALUE(4),
        .ALMOST_EMPTY_VALUE(1), .FWFT(0)
    ) u_dut_reg (
        .clk_in(clk_in), .areset_b(areset_b), .flush(flush), .err_clr(err_clr),
        .trans_write(trans_write), .data_in(data_in), .trans_read(trans_read),
        .data_out(data_out), .data_valid(data_valid), .count(count),
        .full_ind(full_ind), .empty_ind(empty_ind), .threshold_ind(threshold_ind),
        .almost_empty_ind(almost_empty_ind), .overflow_ind(overflow_ind),
        .underflow_ind(underflow_ind)
    );

    fifo_mem_mode #(
        .DATA_WIDTH(16), .OSTD_NUM(8), .THRESHOLD_VALUE(4),
        .ALMOST_EMPTY_VALUE(1), .FWFT(1)
    ) u_dut_fwft (
        .clk_in(clk_in), .areset_b(areset_b), .flush(f_flush), .err_clr(f_err_clr),
        .trans_write(f_wr), .data_in(f_din), .trans_read(f_rd),
        .data_out(f_out), .data_valid(f_valid), .count(f_count),
        .full_ind(f_full), .empty_ind(f_empty), .threshold_ind(f_thresh),
        .almost_empty_ind(f_aempty), .overflow_ind(f_ovf),
        .underflow_ind(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [15:0] v);
        trans_write = 1'b1;
        data_in     = v;
        tick();
        trans_write = 1'b0;
    endtask

    task automatic rd();
        trans_read = 1'b1;
        tick();
        trans_read = 1'b0;
    endtask

    initial begin
        areset_b = 1'b0;
        {flush, err_clr, trans_write, trans_read} = '0;
        {f_flush, f_err_clr, f_wr, f_rd} = '0;
        data_in = '0;
        f_din   = '0;

        #2;
        chk("rst_count",  32'(count), 0);
        chk("rst_empty",  32'(empty_ind), 1);
        chk("rst_aempty", 32'(almost_empty_ind), 1);
        chk("rst_full",   32'(full_ind), 0);
        chk("rst_thresh", 32'(threshold_ind), 0);
        chk("rst_dout",   32'(data_out), 0);
        chk("rst_valid",  32'(data_valid), 0);
        chk("rst_fwft_valid", 32'(f_valid), 0);
        #10 areset_b = 1'b1;
        tick();

        // FWFT instance: write to empty falls through without a read
        f_wr = 1'b1; f_din = 16'h00A5;
        tick();
        f_wr = 1'b0;
        chk("fwft_dout",  32'(f_out), 'hA5);
        chk("fwft_valid", 32'(f_valid), 1);
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        chk("fwft_rd_valid", 32'(f_valid), 0);
        chk("fwft_rd_empty", 32'(f_empty), 1);
        f_wr = 1'b1; f_din = 16'h00B1; tick();
        f_din = 16'h00B2; tick();
        f_wr = 1'b0;
        chk("fwft_head1", 32'(f_out), 'hB1);
        f_rd = 1'b1; tick(); f_rd = 1'b0;
        chk("fwft_head2", 32'(f_out), 'hB2);
        chk("fwft_cnt",   32'(f_count), 1);

        // Fill and overflow
        for (int i = 1; i <= 8; i++) begin
            wr(16'(i));
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_thresh", 32'(threshold_ind), (i >= 4) ? 1 : 0);
            chk("fill_full", 32'(full_ind), (i == 8) ? 1 : 0);
            chk("fill_aempty", 32'(almost_empty_ind), (i <= 1) ? 1 : 0);
        end
        err_clr = 1'b1;
        wr(16'h0009);
        err_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow_ind), 1);
        chk("ovf_count",    32'(count), 8);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow_ind), 0);

        // Drain in registered-read mode with single-cycle valid pulses
        for (int i = 1; i <= 8; i++) begin
            rd();
            chk("drain_data",  32'(data_out), 32'(i));
            chk("drain_valid", 32'(data_valid), 1);
            tick();
            chk("drain_pulse", 32'(data_valid), 0);
            chk("drain_hold",  32'(data_out), 32'(i));
        end
        rd();
        chk("unf_set",   32'(underflow_ind), 1);
        chk("unf_dout",  32'(data_out), 8);
        chk("unf_valid", 32'(data_valid), 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("unf_clr", 32'(underflow_ind), 0);

        // Simultaneous read+write across two pointer wraps
        wr(16'h0100); wr(16'h0101); wr(16'h0102);
        for (int k = 0; k < 20; k++) begin
            trans_write = 1'b1; trans_read = 1'b1; data_in = 16'(16'h0103 + k);
            tick();
            chk("wrap_data",  32'(data_out), 32'(16'h0100 + k));
            chk("wrap_count", 32'(count), 3);
        end
        {trans_write, trans_read} = '0;

        // Flush at count 5 with a pending overflow and a same-edge write
        for (int i = 0; i < 5; i++) wr(16'(16'h0200 + i));
        wr(16'h0300);
        chk("pre_flush_ovf", 32'(overflow_ind), 1);
        rd(); rd(); rd();
        chk("pre_flush_data",  32'(data_out), 'h116);
        chk("pre_flush_count", 32'(count), 5);
        flush = 1'b1; trans_write = 1'b1; data_in = 16'hDEAD;
        tick();
        flush = 1'b0; trans_write = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty_ind), 1);
        chk("flush_ovf",   32'(overflow_ind), 0);
        chk("flush_dout",  32'(data_out), 0);
        chk("flush_valid", 32'(data_valid), 0);
        rd();
        chk("flush_nowrite_unf", 32'(underflow_ind), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Asynchronous reset mid-cycle at count 5
        for (int i = 0; i < 6; i++) wr(16'(16'h0040 + i));
        rd();
        chk("prerst_dout",  32'(data_out), 'h40);
        chk("prerst_count", 32'(count), 5);
        #3 areset_b = 1'b0;
        #1;
        chk("mid_rst_count",  32'(count), 0);
        chk("mid_rst_empty",  32'(empty_ind), 1);
        chk("mid_rst_aempty", 32'(almost_empty_ind), 1);
        chk("mid_rst_dout",   32'(data_out), 0);
        #2 areset_b = 1'b1;
        tick();
        wr(16'hBEEF);
        chk("post_rst_count", 32'(count), 1);
        rd();
        chk("post_rst_data", 32'(data_out), 'hBEEF);
        chk("post_rst_empty", 32'(empty_ind), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_mem_mode.md
FIFO_MEM_MODE -- requirements
Module: fifo_mem_mode

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, entry width in bits.
REQ-002 SHALL have parameter OSTD_NUM, default 8, depth in entries; a power of two, at least 2.
REQ-003 SHALL have parameter THRESHOLD_VALUE, default OSTD_NUM/2, threshold level; range 1..OSTD_NUM.
REQ-004 SHALL have parameter ALMOST_EMPTY_VALUE, default 1, almost-empty level; range 0..OSTD_NUM-1.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk_in, input, 1 bit; the single clock, rising edge.
REQ-007 SHALL have port areset_b, input, 1 bit; reset is asynchronous and active-low.
REQ-008 SHALL have port flush, input, 1 bit; synchronous empty command.
REQ-009 SHALL have port err_clr, input, 1 bit; clears the sticky error flags.
REQ-010 SHALL have port trans_write, input, 1 bit; write request.
REQ-011 SHALL have port data_in, input, DATA_WIDTH bits; write data.
REQ-012 SHALL have port trans_read, input, 1 bit; read request.
REQ-013 SHALL have port data_out, output, DATA_WIDTH bits; read data.
REQ-014 SHALL have port data_valid, output, 1 bit; qualifies data_out.
REQ-015 SHALL have port count, output, $clog2(OSTD_NUM)+1 bits; current occupancy.
REQ-016 SHALL have outputs full_ind, empty_ind, threshold_ind, almost_empty_ind, overflow_ind and underflow_ind, each 1 bit.

Function
REQ-017 SHALL accept a write on a rising edge when trans_write=1, full_ind=0 and flush=0.
REQ-018 SHALL accept a read on a rising edge when trans_read=1, empty_ind=0 and flush=0.
REQ-019 SHALL keep count unchanged on an edge that accepts both a read and a write; otherwise count increments on a write and decrements on a read.
REQ-020 SHALL wrap the read and write pointers (width $clog2(OSTD_NUM)) from OSTD_NUM-1 to 0.
REQ-021 SHALL preserve strict FIFO order across pointer wrap.
REQ-022 SHALL derive the status flags combinationally from the registered count: full_ind=(count==OSTD_NUM), empty_ind=(count==0), threshold_ind=(count>=THRESHOLD_VALUE), almost_empty_ind=(count<=ALMOST_EMPTY_VALUE).
REQ-023 When FWFT=0, SHALL load data_out with the head entry on the edge that accepts a read, assert data_valid for exactly the following cycle, and otherwise hold data_out (1-cycle read latency).
REQ-024 When FWFT=1, SHALL drive data_out with the head entry continuously; data_valid=!empty_ind, and an accepted read advances to the next entry.
REQ-025 In FWFT=1 mode, a write to an empty FIFO SHALL appear on data_out the cycle after the write edge.
REQ-026 SHALL set overflow_ind on the edge where trans_write=1 and full_ind=1 (flush=0); the rejected write does not alter memory, pointers or count.
REQ-027 SHALL set underflow_ind on the edge where trans_read=1 and empty_ind=1 (flush=0); pointers and data_out are unchanged.
REQ-028 SHALL hold overflow_ind and underflow_ind sticky until err_clr, flush or reset; if set and err_clr occur on the same edge, set wins.
REQ-029 On flush=1, SHALL zero the pointers and count, clear both sticky flags, drive data_out=0 and data_valid=0, and ignore any same-edge read or write without raising an error.

Reset
REQ-030 While areset_b=0, SHALL immediately force the pointers, count, data_out, data_valid, overflow_ind and underflow_ind to 0.
REQ-031 While areset_b=0, empty_ind and almost_empty_ind SHALL be 1, and full_ind and threshold_ind SHALL be 0.
REQ-032 Memory contents SHALL not be reset, and no stale entry may be readable after reset.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer; the first accepted write after release SHALL land at address 0.

Verification (DATA_WIDTH=16, OSTD_NUM=8, THRESHOLD_VALUE=4, ALMOST_EMPTY_VALUE=1)
REQ-034 Reset: assert areset_b=0 mid-clock with count=5 -> immediately count=0, empty_ind=1, almost_empty_ind=1, data_out=0x0000.
REQ-035 Fill/overflow: write 0x0001..0x0008 -> threshold_ind=1 after the 4th write, full_ind=1 after the 8th; a 9th write of 0x0009 -> overflow_ind=1, count stays 8; err_clr -> overflow_ind=0.
REQ-036 Drain with FWFT=0: 8 reads -> data_out=0x0001..0x0008, each one cycle after its read with a 1-cycle data_valid pulse; a 9th read -> underflow_ind=1, data_out holds 0x0008.
REQ-037 FWFT=1: write 0x00A5 to the empty FIFO -> next cycle data_out=0x00A5 and data_valid=1 with no read; a read -> data_valid=0, empty_ind=1.
REQ-038 Wrap/simultaneous: hold count=3 and issue 20 consecutive simultaneous read+write cycles with incrementing data -> count stays 3 throughout, read data is in write order, pointers wrap twice.
REQ-039 Flush: at count=5 with trans_write=1 and overflow_ind=1, pulse flush -> next cycle count=0, empty_ind=1, overflow_ind=0, no data written.
